// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: drives rows active-low in turn, samples synchronised columns,
// debounces whole-matrix frames and reports a single pressed key one-hot with press/release strobes.
module keypad_matrix_scanner #(
  parameter int unsigned SCAN_DIV       = 50_000,
  parameter int unsigned DEBOUNCE_SCANS = 5
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [15:0] onehot,
  output logic        key_press,
  output logic        key_release,
  output logic        multi_key
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0] CNT_MAX = 4'hF;
  localparam logic [3:0] DEB_THR = 4'(DEBOUNCE_SCANS);

  logic [3:0]        sync1;
  logic [3:0]        sync2;
  logic [SLOT_W-1:0] slot;
  logic [1:0]        row_idx;
  logic [15:0]       frame;
  logic [15:0]       prev;
  logic [15:0]       debounced;
  logic [3:0]        stable_cnt;
  logic              eval_pend;
  logic [15:0]       onehot_d;

  logic [3:0]  col_s;
  logic        slot_end;
  logic        frame_end;
  logic [15:0] frame_full;
  logic [3:0]  cnt_next;
  logic [4:0]  key_count;

  // Frame-end bookkeeping: the row-3 nibble being sampled now completes the frame.
  always_comb begin
    col_s      = ~sync2;
    slot_end   = (slot == SLOT_LAST);
    frame_end  = slot_end && (row_idx == 2'd3);
    frame_full = {col_s, frame[11:0]};
    cnt_next   = 4'd1;
    if (frame_full == prev) begin
      cnt_next = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 4'd1;
    end
    key_count  = 5'($countones(debounced));
  end

  always_ff @(posedge clk) begin
    if (RSTn) begin
      sync1       <= 4'hF;
      sync2       <= 4'hF;
      slot        <= '0;
      row_idx     <= 2'd0;
      row         <= 4'b1110;
      frame       <= '0;
      prev        <= '0;
      debounced   <= '0;
      stable_cnt  <= '0;
      eval_pend   <= 1'b0;
      onehot      <= '0;
      onehot_d    <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      sync1 <= col;
      sync2 <= sync1;

      if (slot_end) begin
        slot                      <= '0;
        frame[{row_idx, 2'b00} +: 4] <= col_s;
        row_idx                   <= row_idx + 2'd1;
        row                       <= {row[2:0], row[3]};
      end else begin
        slot <= slot + SLOT_W'(1);
      end

      // prev holds the just-completed frame until the next frame end, so it is the update source.
      eval_pend <= 1'b0;
      if (frame_end) begin
        prev       <= frame_full;
        stable_cnt <= cnt_next;
        eval_pend  <= (cnt_next >= DEB_THR) && (frame_full != debounced);
      end
      if (eval_pend) begin
        debounced <= prev;
      end

      onehot    <= (key_count == 5'd1) ? debounced : 16'h0000;
      multi_key <= (key_count >= 5'd2);

      onehot_d    <= onehot;
      key_press   <= (onehot != onehot_d) && (onehot != 16'h0000);
      key_release <= (onehot_d != 16'h0000) && (onehot == 16'h0000);
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: keypad model, table-driven steps, strobe scoreboard,
// and hand-written bounce and mid-frame reset sequences.
module tb_keypad_matrix_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;
  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        RSTn;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] onehot;
  logic        key_press;
  logic        key_release;
  logic        multi_key;
  logic [15:0] keys;

  int errors = 0;
  int checks = 0;
  int press_cnt = 0;
  int rel_cnt = 0;
  int row_bad = 0;

  typedef struct packed {
    logic        is_press;
    logic [15:0] code;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [15:0] keys;
    int          frames;
    logic [15:0] exp_onehot;
    logic        exp_multi;
    int          exp_press;
    int          exp_rel;
  } step_t;
  step_t steps[8];

  keypad_matrix_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .RSTn(RSTn), .col(col), .row(row), .onehot(onehot),
    .key_press(key_press), .key_release(key_release), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Key (r,c) pressed pulls column c low while row r is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe scoreboard and row-drive sanity.
  always @(negedge clk) begin
    if ($countones(~row) != 1) row_bad++;
    if (key_press) press_cnt++;
    if (key_release) rel_cnt++;
    if (key_press || key_release) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: press=%b release=%b onehot=%h at %0t",
                 key_press, key_release, onehot, $time);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (key_press !== e.is_press || key_release !== !e.is_press || onehot !== e.code) begin
          errors++;
          $display("FAIL strobe_event: got press=%b code=%h expected press=%b code=%h at %0t",
                   key_press, onehot, e.is_press, e.code, $time);
        end
      end
    end
  end

  task automatic push_ev(input logic is_press, input logic [15:0] code);
    ev_t e;
    e.is_press = is_press;
    e.code     = code;
    exp_q.push_back(e);
  endtask

  // Stop on the negedge right after a frame boundary (row just rotated back to 1110).
  task automatic align_frame();
    logic [3:0] last;
    bit found;
    last  = row;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (row == 4'b1110 && last == 4'b0111) found = 1;
      last = row;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL align_frame: timeout waiting for frame boundary");
    end
  endtask

  initial begin
    int p0, r0, bad;
    logic [3:0] exp_row;

    steps[0] = '{16'h0000, 4, 16'h0000, 1'b0, 0, 0};
    steps[1] = '{16'h0040, 6, 16'h0040, 1'b0, 1, 0};
    steps[2] = '{16'h0000, 6, 16'h0000, 1'b0, 0, 1};
    steps[3] = '{16'h0201, 6, 16'h0000, 1'b1, 0, 0};
    steps[4] = '{16'h0001, 6, 16'h0001, 1'b0, 1, 0};
    steps[5] = '{16'h0040, 6, 16'h0040, 1'b0, 1, 0};
    steps[6] = '{16'h0013, 6, 16'h0000, 1'b1, 0, 1};
    steps[7] = '{16'h0000, 6, 16'h0000, 1'b0, 0, 0};

    keys = 16'h0000;
    RSTn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_row", 16'(row), 16'h000E);
    chk("reset_onehot", onehot, 16'h0000);
    chk("reset_strobes", {13'd0, key_press, key_release, multi_key}, 16'h0000);
    RSTn = 1'b0;

    // Row rotation, 4 cycles per row starting from reset.
    exp_row = 4'b1110;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0 && i % 4 == 0) exp_row = {exp_row[2:0], exp_row[3]};
      if (row !== exp_row || onehot !== 16'h0 || key_press || key_release) bad++;
      @(negedge clk);
    end
    chk("row_sequence_bad_cycles", 16'(bad), 16'h0000);

    for (int s = 0; s < 8; s++) begin
      keys = steps[s].keys;
      p0 = press_cnt;
      r0 = rel_cnt;
      if (steps[s].exp_press != 0) push_ev(1'b1, steps[s].exp_onehot);
      if (steps[s].exp_rel != 0) push_ev(1'b0, 16'h0000);
      repeat (steps[s].frames * FRAME) @(negedge clk);
      chk($sformatf("step%0d_onehot", s), onehot, steps[s].exp_onehot);
      chk($sformatf("step%0d_multi", s), 16'(multi_key), 16'(steps[s].exp_multi));
      chk($sformatf("step%0d_press_cnt", s), 16'(press_cnt - p0), 16'(steps[s].exp_press));
      chk($sformatf("step%0d_release_cnt", s), 16'(rel_cnt - r0), 16'(steps[s].exp_rel));
    end

    // Key (3,3) bounces frame by frame, then holds: exactly DEB frames to output.
    align_frame();
    p0 = press_cnt;
    bad = 0;
    for (int f = 0; f < 4; f++) begin
      keys = (f % 2 == 0) ? 16'h8000 : 16'h0000;
      repeat (FRAME) begin
        @(negedge clk);
        if (onehot !== 16'h0) bad++;
      end
    end
    keys = 16'h8000;
    push_ev(1'b1, 16'h8000);
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (onehot !== 16'h0) bad++;
    end
    chk("bounce_held_zero_cycles", 16'(bad), 16'h0000);
    repeat (2) @(negedge clk);
    chk("bounce_onehot_latency", onehot, 16'h8000);
    repeat (4) @(negedge clk);
    chk("bounce_press_cnt", 16'(press_cnt - p0), 16'd1);
    keys = 16'h0000;
    push_ev(1'b0, 16'h0000);
    repeat (6 * FRAME) @(negedge clk);
    chk("bounce_release_onehot", onehot, 16'h0000);

    // Reset in the middle of row 2 while (1,2) is held.
    keys = 16'h0040;
    push_ev(1'b1, 16'h0040);
    repeat (6 * FRAME) @(negedge clk);
    chk("pre_reset_onehot", onehot, 16'h0040);
    bad = 1;
    for (int i = 0; i < 20 && bad != 0; i++) begin
      @(negedge clk);
      if (row == 4'b1011) bad = 0;
    end
    chk("find_row2", 16'(bad), 16'h0000);
    @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);
    chk("midreset_row", 16'(row), 16'h000E);
    chk("midreset_onehot", onehot, 16'h0000);
    chk("midreset_strobes", {13'd0, key_press, key_release, multi_key}, 16'h0000);
    RSTn = 1'b0;
    push_ev(1'b1, 16'h0040);
    repeat (49) @(negedge clk);
    chk("post_reset_not_yet", onehot, 16'h0000);
    @(negedge clk);
    chk("post_reset_onehot", onehot, 16'h0040);
    keys = 16'h0000;
    push_ev(1'b0, 16'h0000);
    repeat (6 * FRAME) @(negedge clk);
    chk("final_onehot", onehot, 16'h0000);

    chk("scoreboard_empty", 16'(exp_q.size()), 16'h0000);
    chk("row_one_low_bad_cycles", 16'(row_bad), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
